ysyx_24090013_lut_cam: RTL and testbench

Programmable, pipelined key-to-data lookup table: the sequential successor of the combinational key mux. It holds NR_KEY runtime-writable (key, data, valid) entries, accepts one lookup per cycle over a valid/ready handshake, and returns data, hit, multi-hit and matched index two cycles later. It serves NPC decode and CSR-address lookup paths where tables must be rewritten at runtime and the compare must be off the critical path.

---
 rtl/ysyx_24090013_lut_pkg.sv | 13 +
 rtl/ysyx_24090013_lut_cam_if.sv | 33 +++
 rtl/ysyx_24090013_lut_match.sv | 41 ++++
 rtl/ysyx_24090013_lut_cam.sv | 82 ++++++++
 tb/tb_ysyx_24090013_lut_cam.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24090013_lut_pkg.sv
// ysyx_24090013_lut_pkg: shared sizing helper and table-entry field layout for the lookup CAM.
package ysyx_24090013_lut_pkg;
    localparam int DATA_LSB = 0;
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
    function automatic int key_lsb(input int data_len);
        return data_len;
    endfunction
    function automatic int vld_bit(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction
endpackage

// File: rtl/ysyx_24090013_lut_cam_if.sv
// ysyx_24090013_lut_cam_if: table-write, lookup-request and response bundle of the lookup CAM.
interface ysyx_24090013_lut_cam_if
    import ysyx_24090013_lut_pkg::*;
#(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32,
    parameter int IDX_W    = idx_w(NR_KEY)
);
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                wr_vld;
    logic [DATA_LEN-1:0] default_out;
    logic                req_valid;
    logic                req_ready;
    logic [KEY_LEN-1:0]  req_key;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_LEN-1:0] rsp_data;
    logic                rsp_hit;
    logic                rsp_multi;
    logic [IDX_W-1:0]    rsp_idx;
    modport master (
        output wr_en, wr_idx, wr_key, wr_data, wr_vld, default_out, req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_multi, rsp_idx
    );
    modport slave (
        input  wr_en, wr_idx, wr_key, wr_data, wr_vld, default_out, req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_multi, rsp_idx
    );
endinterface

// File: rtl/ysyx_24090013_lut_match.sv
// ysyx_24090013_lut_match: key compare, hit/multi detect, lowest-index encoder and miss/merge select.
module ysyx_24090013_lut_match
    import ysyx_24090013_lut_pkg::*;
#(
    parameter int NR_KEY      = 8,
    parameter int KEY_LEN     = 7,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 1,
    parameter int PRIORITY    = 1,
    parameter int IDX_W       = idx_w(NR_KEY)
) (
    input  logic [NR_KEY-1:0]               vld,
    input  logic [NR_KEY-1:0][KEY_LEN-1:0]  keys,
    input  logic [NR_KEY-1:0][DATA_LEN-1:0] datas,
    input  logic [KEY_LEN-1:0]              key,
    input  logic [DATA_LEN-1:0]             default_out,
    output logic [DATA_LEN-1:0]             data,
    output logic                            hit,
    output logic                            multi,
    output logic [IDX_W-1:0]                idx
);
    logic [NR_KEY-1:0]   m;
    logic [DATA_LEN-1:0] pri;
    logic [DATA_LEN-1:0] orr;
    always_comb begin
        m   = '0;
        idx = '0;
        pri = '0;
        orr = '0;
        for (int i = 0; i < NR_KEY; i++) m[i] = vld[i] && (keys[i] == key);
        // scan downward so the lowest matching entry is the last one written
        for (int i = NR_KEY - 1; i >= 0; i--) if (m[i]) begin
            idx = IDX_W'(i);
            pri = datas[i];
        end
        for (int i = 0; i < NR_KEY; i++) orr = orr | (datas[i] & {DATA_LEN{m[i]}});
    end
    assign hit   = |m;
    assign multi = |(m & (m - NR_KEY'(1)));
    assign data  = hit ? ((PRIORITY != 0) ? pri : orr) : ((HAS_DEFAULT != 0) ? default_out : '0);
endmodule

// File: rtl/ysyx_24090013_lut_cam.sv
// ysyx_24090013_lut_cam: runtime-writable key/data table with a two-stage valid/ready lookup pipeline.
module ysyx_24090013_lut_cam
    import ysyx_24090013_lut_pkg::*;
#(
    parameter int NR_KEY      = 8,
    parameter int KEY_LEN     = 7,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 1,
    parameter int PRIORITY    = 1,
    parameter int IDX_W       = idx_w(NR_KEY)
) (
    input logic                    clk,
    input logic                    rst_n,
    ysyx_24090013_lut_cam_if.slave bus
);
    localparam int KEY_LSB = key_lsb(DATA_LEN);
    localparam int VLD_BIT = vld_bit(KEY_LEN, DATA_LEN);
    localparam int EW      = VLD_BIT + 1;
    logic [NR_KEY-1:0][EW-1:0]       tbl;
    logic [NR_KEY-1:0]               vld;
    logic [NR_KEY-1:0][KEY_LEN-1:0]  keys;
    logic [NR_KEY-1:0][DATA_LEN-1:0] datas;
    logic                            rdy_q;
    logic                            s1_valid;
    logic [KEY_LEN-1:0]              s1_key;
    logic                            s1_adv;
    logic                            s2_adv;
    logic [DATA_LEN-1:0]             m_data;
    logic                            m_hit;
    logic                            m_multi;
    logic [IDX_W-1:0]                m_idx;
    // indices with no matching entry simply never decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbl <= '0;
        else if (bus.wr_en) for (int i = 0; i < NR_KEY; i++)
            if (bus.wr_idx == IDX_W'(i)) tbl[i] <= {bus.wr_vld, bus.wr_key, bus.wr_data};
    end
    for (genvar i = 0; i < NR_KEY; i++) begin : g_ent
        assign vld[i]   = tbl[i][VLD_BIT];
        assign keys[i]  = tbl[i][KEY_LSB +: KEY_LEN];
        assign datas[i] = tbl[i][DATA_LSB +: DATA_LEN];
    end
    assign s2_adv        = !bus.rsp_valid | bus.rsp_ready;
    assign s1_adv        = s1_valid & s2_adv;
    // rdy_q keeps req_ready low through reset and its release cycle
    assign bus.req_ready = rdy_q & (!s1_valid | s2_adv);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            s1_valid <= 1'b0;
            s1_key   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (bus.req_ready) s1_valid <= bus.req_valid;
            if (bus.req_ready && bus.req_valid) s1_key <= bus.req_key;
        end
    end
    ysyx_24090013_lut_match #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
        .HAS_DEFAULT(HAS_DEFAULT), .PRIORITY(PRIORITY), .IDX_W(IDX_W)
    ) u_match (
        .vld(vld), .keys(keys), .datas(datas), .key(s1_key), .default_out(bus.default_out),
        .data(m_data), .hit(m_hit), .multi(m_multi), .idx(m_idx)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_multi <= 1'b0;
            bus.rsp_idx   <= '0;
        end else begin
            if (s2_adv) bus.rsp_valid <= s1_valid;
            if (s1_adv) begin
                bus.rsp_data  <= m_data;
                bus.rsp_hit   <= m_hit;
                bus.rsp_multi <= m_multi;
                bus.rsp_idx   <= m_idx;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24090013_lut_cam.sv
// tb_ysyx_24090013_lut_cam: directed checks of the lookup CAM in priority/default and OR-merge/zero-miss builds.
module tb_ysyx_24090013_lut_cam;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    ysyx_24090013_lut_cam_if #(.NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32)) bus_a ();
    ysyx_24090013_lut_cam_if #(.NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32)) bus_b ();
    assign bus_b.wr_en       = bus_a.wr_en;
    assign bus_b.wr_idx      = bus_a.wr_idx;
    assign bus_b.wr_key      = bus_a.wr_key;
    assign bus_b.wr_data     = bus_a.wr_data;
    assign bus_b.wr_vld      = bus_a.wr_vld;
    assign bus_b.default_out = bus_a.default_out;
    assign bus_b.req_valid   = bus_a.req_valid;
    assign bus_b.req_key     = bus_a.req_key;
    assign bus_b.rsp_ready   = bus_a.rsp_ready;
    ysyx_24090013_lut_cam #(.NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32), .HAS_DEFAULT(1), .PRIORITY(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    ysyx_24090013_lut_cam #(.NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32), .HAS_DEFAULT(0), .PRIORITY(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    // {valid, hit, multi, idx, data}
    wire [37:0] ra = {bus_a.rsp_valid, bus_a.rsp_hit, bus_a.rsp_multi, bus_a.rsp_idx, bus_a.rsp_data};
    wire [37:0] rb = {bus_b.rsp_valid, bus_b.rsp_hit, bus_b.rsp_multi, bus_b.rsp_idx, bus_b.rsp_data};
    localparam logic [37:0] MISS_A = {1'b1, 1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF};
    localparam logic [37:0] MISS_B = {1'b1, 1'b0, 1'b0, 3'd0, 32'h0};

    task automatic wr(input logic [2:0] idx, input logic [6:0] key, input logic [31:0] data, input logic v);
        bus_a.wr_en = 1'b1;
        bus_a.wr_idx = idx;
        bus_a.wr_key = key;
        bus_a.wr_data = data;
        bus_a.wr_vld = v;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [6:0] key);
        bus_a.rsp_ready = 1'b1;
        bus_a.req_valid = 1'b1;
        bus_a.req_key = key;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ra !== 38'd0) begin n_fail++; $display("FAIL reset_rsp_a: got %h expected %h", ra, 38'd0); end
        n_chk++;
        if (rb !== 38'd0) begin n_fail++; $display("FAIL reset_rsp_b: got %h expected %h", rb, 38'd0); end
        n_chk++;
        if (bus_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", bus_a.req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", bus_a.req_ready); end
    endtask

    task automatic test_miss();
        lookup(7'h33);
        n_chk++;
        if (ra !== MISS_A) begin n_fail++; $display("FAIL miss_default: got %h expected %h", ra, MISS_A); end
        n_chk++;
        if (rb !== MISS_B) begin n_fail++; $display("FAIL miss_zero: got %h expected %h", rb, MISS_B); end
    endtask

    task automatic test_basic_hit();
        logic [37:0] exp_r;
        exp_r = {1'b1, 1'b1, 1'b0, 3'd2, 32'hAAAA_0001};
        wr(3'd2, 7'h13, 32'hAAAA_0001, 1'b1);
        bus_a.req_valid = 1'b1;
        bus_a.req_key = 7'h13;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        n_chk++;
        if (bus_a.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b expected 0", bus_a.rsp_valid); end
        @(negedge clk);
        n_chk++;
        if (ra !== exp_r) begin n_fail++; $display("FAIL basic_hit_a: got %h expected %h", ra, exp_r); end
        n_chk++;
        if (rb !== exp_r) begin n_fail++; $display("FAIL basic_hit_b: got %h expected %h", rb, exp_r); end
    endtask

    task automatic test_multi();
        logic [37:0] exp_a;
        logic [37:0] exp_b;
        exp_a = {1'b1, 1'b1, 1'b1, 3'd1, 32'h10};
        exp_b = {1'b1, 1'b1, 1'b1, 3'd1, 32'h13};
        wr(3'd1, 7'h0F, 32'h10, 1'b1);
        wr(3'd5, 7'h0F, 32'h03, 1'b1);
        lookup(7'h0F);
        n_chk++;
        if (ra !== exp_a) begin n_fail++; $display("FAIL multi_priority: got %h expected %h", ra, exp_a); end
        n_chk++;
        if (rb !== exp_b) begin n_fail++; $display("FAIL multi_or_merge: got %h expected %h", rb, exp_b); end
    endtask

    task automatic test_invalid_entry();
        wr(3'd6, 7'h22, 32'h77, 1'b0);
        lookup(7'h22);
        n_chk++;
        if (ra !== MISS_A) begin n_fail++; $display("FAIL invalid_no_match: got %h expected %h", ra, MISS_A); end
    endtask

    task automatic test_last_write();
        logic [37:0] exp_r;
        exp_r = {1'b1, 1'b1, 1'b0, 3'd3, 32'h2};
        bus_a.wr_en = 1'b1;
        bus_a.wr_idx = 3'd3;
        bus_a.wr_key = 7'h40;
        bus_a.wr_data = 32'h1;
        bus_a.wr_vld = 1'b1;
        @(negedge clk);
        bus_a.wr_data = 32'h2;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        lookup(7'h40);
        n_chk++;
        if (ra !== exp_r) begin n_fail++; $display("FAIL last_write_wins: got %h expected %h", ra, exp_r); end
    endtask

    task automatic test_write_race();
        logic [37:0] exp_r;
        exp_r = {1'b1, 1'b1, 1'b0, 3'd0, 32'h55};
        bus_a.req_valid = 1'b1;
        bus_a.req_key = 7'h05;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        wr(3'd0, 7'h05, 32'h55, 1'b1);
        n_chk++;
        if (ra !== MISS_A) begin n_fail++; $display("FAIL race_same_cycle: got %h expected %h", ra, MISS_A); end
        lookup(7'h05);
        n_chk++;
        if (ra !== exp_r) begin n_fail++; $display("FAIL race_next_hit: got %h expected %h", ra, exp_r); end
        wr(3'd0, 7'h05, 32'h55, 1'b0);
        lookup(7'h05);
        n_chk++;
        if (ra !== MISS_A) begin n_fail++; $display("FAIL invalidate_miss: got %h expected %h", ra, MISS_A); end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  k [4];
        logic [37:0] exp_r [4];
        logic [37:0] held;
        logic        stall;
        logic        exp_rdy;
        int          sent;
        int          got;
        k = '{7'h13, 7'h0F, 7'h33, 7'h40};
        exp_r = '{{1'b1, 1'b1, 1'b0, 3'd2, 32'hAAAA_0001}, {1'b1, 1'b1, 1'b1, 3'd1, 32'h10},
                  MISS_A, {1'b1, 1'b1, 1'b0, 3'd3, 32'h2}};
        sent = 0;
        got = 0;
        stall = 1'b0;
        held = '0;
        bus_a.rsp_ready = 1'b1;
        bus_a.req_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            if (stall) begin
                n_chk++;
                if (ra !== held) begin n_fail++; $display("FAIL b2b_stable c%0d: got %h expected %h", c, ra, held); end
            end
            bus_a.rsp_ready = !(c >= 3 && c <= 5);
            bus_a.req_valid = (sent < 4);
            bus_a.req_key = (sent < 4) ? k[sent] : 7'h0;
            #1;
            exp_rdy = ((sent - got) < 2) || bus_a.rsp_ready;
            n_chk++;
            if (bus_a.req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_req_ready c%0d: got %b expected %b", c, bus_a.req_ready, exp_rdy);
            end
            if (bus_a.rsp_valid && bus_a.rsp_ready) begin
                n_chk++;
                if (got >= 4) begin n_fail++; $display("FAIL b2b_extra_rsp c%0d: got %h expected none", c, ra); end
                else if (ra !== exp_r[got]) begin n_fail++; $display("FAIL b2b_rsp%0d: got %h expected %h", got, ra, exp_r[got]); end
                got++;
            end
            stall = bus_a.rsp_valid && !bus_a.rsp_ready;
            held = ra;
            if (bus_a.req_valid && bus_a.req_ready) sent++;
            @(negedge clk);
        end
        bus_a.req_valid = 1'b0;
        bus_a.rsp_ready = 1'b1;
        n_chk++;
        if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", got); end
    endtask

    task automatic test_reset_mid();
        bus_a.rsp_ready = 1'b0;
        bus_a.req_valid = 1'b1;
        bus_a.req_key = 7'h13;
        @(negedge clk);
        bus_a.req_key = 7'h0F;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus_a.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus_a.rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (ra !== 38'd0) begin n_fail++; $display("FAIL mid_reset_rsp: got %h expected %h", ra, 38'd0); end
        n_chk++;
        if (bus_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", bus_a.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++;
            if (bus_a.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale c%0d: got %b expected 0", c, bus_a.rsp_valid); end
        end
        lookup(7'h13);
        n_chk++;
        if (ra !== MISS_A) begin n_fail++; $display("FAIL mid_table_empty: got %h expected %h", ra, MISS_A); end
    endtask

    initial begin
        bus_a.wr_en = 1'b0;
        bus_a.wr_idx = '0;
        bus_a.wr_key = '0;
        bus_a.wr_data = '0;
        bus_a.wr_vld = 1'b0;
        bus_a.default_out = 32'hDEAD_BEEF;
        bus_a.req_valid = 1'b0;
        bus_a.req_key = '0;
        bus_a.rsp_ready = 1'b1;
        test_reset();
        test_miss();
        test_basic_hit();
        test_multi();
        test_invalid_entry();
        test_last_write();
        test_write_race();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
